// File: rtl/drive_pwm_pkg.sv
// drive_pwm_pkg: drive-code encodings and the code-to-duty mapping shared by
// the drive_pwm top level and its pwm_channel instances.
package drive_pwm_pkg;

  localparam logic [1:0] DRV_OFF  = 2'd0;
  localparam logic [1:0] DRV_LOW  = 2'd1;
  localparam logic [1:0] DRV_HIGH = 2'd2;
  localparam logic [1:0] DRV_RSVD = 2'd3;

  // Reserved code is deliberately treated as a stop.
  function automatic int unsigned drive_target(input logic [1:0]  code,
                                               input int unsigned duty_low,
                                               input int unsigned duty_high);
    int unsigned target;
    case (code)
      DRV_LOW:            target = duty_low;
      DRV_HIGH:           target = duty_high;
      DRV_OFF, DRV_RSVD:  target = 0;
      default:            target = 0;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one motor channel. Latches the drive code on the wrap strobe,
// slews the duty register toward the new target, and registers the compare
// output against the shared period counter.
// Build option: DRIVE_PWM_RAMP_EN enables slew limiting; when undefined the
// duty jumps straight to the target on every wrap.
module pwm_channel
  import drive_pwm_pkg::*;
#(
  parameter int unsigned PERIOD    = 100000,
  parameter int unsigned DUTY_LOW  = 60000,
  parameter int unsigned DUTY_HIGH = 90000,
  parameter int unsigned RAMP_STEP = 5000,
  parameter int unsigned CW        = 17
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wrap,
  input  logic [1:0]    i_drive,
  input  logic [CW-1:0] i_cnt,
  output logic          o_pwm,
  output logic          o_at_target
);

  localparam int unsigned DW = $clog2(PERIOD + 1);

  logic [DW-1:0] r_target;
  logic [DW-1:0] r_duty;
  logic [DW-1:0] w_code_target;
  logic [DW-1:0] w_duty_next;
  logic          r_pwm;

  assign w_code_target = DW'(drive_target(i_drive, DUTY_LOW, DUTY_HIGH));

`ifdef DRIVE_PWM_RAMP_EN
  // Next duty: stops are immediate, otherwise move at most RAMP_STEP toward target.
  // Differences are formed only in the direction that cannot underflow.
  always_comb begin
    w_duty_next = r_duty;
    if (w_code_target == '0) begin
      w_duty_next = '0;
    end else if (r_duty < w_code_target) begin
      if (32'(w_code_target - r_duty) > RAMP_STEP) begin
        w_duty_next = r_duty + DW'(RAMP_STEP);
      end else begin
        w_duty_next = w_code_target;
      end
    end else if (r_duty > w_code_target) begin
      if (32'(r_duty - w_code_target) > RAMP_STEP) begin
        w_duty_next = r_duty - DW'(RAMP_STEP);
      end else begin
        w_duty_next = w_code_target;
      end
    end
  end
`else
  logic w_unused_ramp_step;
  assign w_unused_ramp_step = ^RAMP_STEP;

  // Next duty: jump straight to the sampled target.
  always_comb begin
    w_duty_next = r_duty;
    w_duty_next = w_code_target;
  end
`endif

  // Target latch and duty register, updated only on the period wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_target <= '0;
      r_duty   <= '0;
    end else if (i_wrap) begin
      r_target <= w_code_target;
      r_duty   <= w_duty_next;
    end
  end

  // Registered compare; the async reset forces the enable low immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (32'(i_cnt) < 32'(r_duty));
    end
  end

  assign o_pwm       = r_pwm;
  assign o_at_target = (r_duty == r_target);

endmodule

// File: rtl/drive_pwm.sv
// drive_pwm: turns movement-FSM drive codes into slew-limited PWM enables for
// two H-bridge channels sharing one free-running period counter.
// Build option: DRIVE_PWM_RAMP_EN (see pwm_channel) selects ramped duty updates.
module drive_pwm
  import drive_pwm_pkg::*;
#(
  parameter int unsigned PERIOD    = 100000,
  parameter int unsigned DUTY_LOW  = 60000,
  parameter int unsigned DUTY_HIGH = 90000,
  parameter int unsigned RAMP_STEP = 5000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] DriveA,
  input  logic [1:0] DriveB,
  output logic       PWMA,
  output logic       PWMB,
  output logic       Settled
);

  localparam int unsigned CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;
  logic          w_at_target_a;
  logic          w_at_target_b;

  assign w_wrap = (r_cnt == CW'(PERIOD - 1));

  // Shared period counter, 0..PERIOD-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  pwm_channel #(
    .PERIOD    (PERIOD),
    .DUTY_LOW  (DUTY_LOW),
    .DUTY_HIGH (DUTY_HIGH),
    .RAMP_STEP (RAMP_STEP),
    .CW        (CW)
  ) u_chan_a (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_wrap      (w_wrap),
    .i_drive     (DriveA),
    .i_cnt       (r_cnt),
    .o_pwm       (PWMA),
    .o_at_target (w_at_target_a)
  );

  pwm_channel #(
    .PERIOD    (PERIOD),
    .DUTY_LOW  (DUTY_LOW),
    .DUTY_HIGH (DUTY_HIGH),
    .RAMP_STEP (RAMP_STEP),
    .CW        (CW)
  ) u_chan_b (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_wrap      (w_wrap),
    .i_drive     (DriveB),
    .i_cnt       (r_cnt),
    .o_pwm       (PWMB),
    .o_at_target (w_at_target_b)
  );

  assign Settled = w_at_target_a & w_at_target_b;

endmodule

// File: tb/tb_drive_pwm.sv
// Directed bench for drive_pwm with PERIOD=100, DUTY_LOW=60, DUTY_HIGH=90,
// RAMP_STEP=25. Expected high times follow the DRIVE_PWM_RAMP_EN build setting.
module tb_drive_pwm;

  logic       clk;
  logic       rst;
  logic [1:0] drv_a;
  logic [1:0] drv_b;
  logic       pwm_a;
  logic       pwm_b;
  logic       settled;

  int n_checks = 0;
  int n_err    = 0;
  int ha;
  int hb;
  int sc;

`ifdef DRIVE_PWM_RAMP_EN
  localparam int UP_LOW [4]  = '{25, 50, 60, 60};
  localparam int SET_LOW [4] = '{0, 1, 1, 1};
  localparam int SET_LOW0    = 0;
  localparam int LOW_HIGH [2] = '{85, 90};
  localparam int UP_HIGH [4] = '{25, 50, 75, 90};
`else
  localparam int UP_LOW [4]  = '{60, 60, 60, 60};
  localparam int SET_LOW [4] = '{1, 1, 1, 1};
  localparam int SET_LOW0    = 1;
  localparam int LOW_HIGH [2] = '{90, 90};
  localparam int UP_HIGH [4] = '{90, 90, 90, 90};
`endif

  drive_pwm #(
    .PERIOD    (100),
    .DUTY_LOW  (60),
    .DUTY_HIGH (90),
    .RAMP_STEP (25)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .DriveA  (drv_a),
    .DriveB  (drv_b),
    .PWMA    (pwm_a),
    .PWMB    (pwm_b),
    .Settled (settled)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bv(input logic b);
    return (b === 1'b1) ? 1 : ((b === 1'b0) ? 0 : -1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One output period: 100 cycles sampled on the falling edge.
  task automatic run_period(output int high_a, output int high_b, output int set_cnt);
    high_a  = 0;
    high_b  = 0;
    set_cnt = 0;
    repeat (100) begin
      @(posedge clk);
      @(negedge clk);
      if (pwm_a === 1'b1) high_a++;
      if (pwm_b === 1'b1) high_b++;
      if (settled === 1'b1) set_cnt++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    drv_a = 2'd0;
    drv_b = 2'd0;
    repeat (2) @(negedge clk);
    check("reset_pwma", bv(pwm_a), 0);
    check("reset_pwmb", bv(pwm_b), 0);
    check("reset_settled", bv(settled), 1);
    rst = 1'b0;

    // Idle: both off for five periods.
    for (int i = 0; i < 5; i++) begin
      run_period(ha, hb, sc);
      check($sformatf("idle%0d_ha", i), ha, 0);
      check($sformatf("idle%0d_hb", i), hb, 0);
      check($sformatf("idle%0d_settled", i), sc, 100);
    end

    // A: off -> low.
    drv_a = 2'd1;
    run_period(ha, hb, sc);
    check("low_pre_ha", ha, 0);
    check("low_pre_settled", bv(settled), SET_LOW0);
    for (int i = 0; i < 4; i++) begin
      run_period(ha, hb, sc);
      check($sformatf("low%0d_ha", i), ha, UP_LOW[i]);
      check($sformatf("low%0d_settled", i), bv(settled), SET_LOW[i]);
    end

    // A: low -> high.
    drv_a = 2'd2;
    run_period(ha, hb, sc);
    check("high_pre_ha", ha, 60);
    for (int i = 0; i < 2; i++) begin
      run_period(ha, hb, sc);
      check($sformatf("high%0d_ha", i), ha, LOW_HIGH[i]);
    end

    // A: high -> off is never ramped.
    drv_a = 2'd0;
    run_period(ha, hb, sc);
    check("stop_pre_ha", ha, 90);
    check("stop_settled", bv(settled), 1);
    run_period(ha, hb, sc);
    check("stop_ha", ha, 0);

    // A high and B reserved together.
    drv_a = 2'd2;
    drv_b = 2'd3;
    run_period(ha, hb, sc);
    check("sim_pre_ha", ha, 0);
    check("sim_pre_hb", hb, 0);
    for (int i = 0; i < 4; i++) begin
      run_period(ha, hb, sc);
      check($sformatf("sim%0d_ha", i), ha, UP_HIGH[i]);
      check($sformatf("sim%0d_hb", i), hb, 0);
    end

    // Reset pulse during the high phase of a settled period.
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_pwma", bv(pwm_a), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pwma", bv(pwm_a), 0);
    check("async_rst_settled", bv(settled), 1);
    @(negedge clk);
    rst = 1'b0;
    run_period(ha, hb, sc);
    check("post_rst_pre_ha", ha, 0);
    for (int i = 0; i < 4; i++) begin
      run_period(ha, hb, sc);
      check($sformatf("post_rst%0d_ha", i), ha, UP_HIGH[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
